// File: rtl/lectura_rtc.sv
// +----------------------------------------------------------------------------+
// | Module      : lectura_rtc                                                  |
// | Description : Read sequencer for the RTC parallel address/data bus. On a   |
// |               read request it sweeps registers 0x21..0x26 and 0x41..0x43.  |
// |               For each one it holds the address, then raises a read strobe  |
// |               and captures the returned byte into its own output register. |
// |               The address bus is tri-stated whenever no sweep is running.  |
// | Option      : define BCD_CHECK_EN to reject captured bytes that are not    |
// |               valid packed BCD and flag them on bcd_err.                   |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
`default_nettype none

module lectura_rtc #(
  parameter logic [11:0] HOLD = 12'h04A
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       leer,
  input  logic       escribe,
  input  logic [7:0] data_in,
  output logic [7:0] address,
  output logic       rd,
  output logic       busy,
  output logic       done,
  output logic [7:0] seg,
  output logic [7:0] min,
  output logic [7:0] hora,
  output logic [7:0] dia,
  output logic [7:0] mes,
  output logic [7:0] anio,
  output logic [7:0] t_seg,
  output logic [7:0] t_min,
  output logic [7:0] t_hora,
  output logic       bcd_err
);

  localparam logic [3:0]  c_last_idx = 4'd8;
  localparam logic [11:0] c_cnt_one  = 12'd1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ADDR = 2'd1,
    S_READ = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t      r_state;
  logic [3:0]  r_idx;
  logic [11:0] r_cnt;
  logic [7:0]  r_addr;
  logic        r_drive;
  logic        r_rd;
  logic        r_busy;
  logic        r_done;
  logic [7:0]  r_data [0:8];

  logic        w_start;
  logic        w_phase_end;

  // Register address for each sweep position: time block then timer block.
  function automatic logic [7:0] addr_of(input logic [3:0] idx);
    logic [7:0] a;
    case (idx)
      4'd0:    a = 8'h21;
      4'd1:    a = 8'h22;
      4'd2:    a = 8'h23;
      4'd3:    a = 8'h24;
      4'd4:    a = 8'h25;
      4'd5:    a = 8'h26;
      4'd6:    a = 8'h41;
      4'd7:    a = 8'h42;
      4'd8:    a = 8'h43;
      default: a = 8'h00;
    endcase
    return a;
  endfunction

  // A sweep may only start while no writer owns the bus.
  assign w_start     = leer & ~escribe;
  // The counter runs 1..HOLD inside every phase, so HOLD marks the last clock.
  assign w_phase_end = (r_cnt == HOLD);

`ifdef BCD_CHECK_EN
  logic r_bcd_err;
  logic w_byte_ok;

  // Both nibbles must be decimal digits for the byte to be accepted.
  assign w_byte_ok = (data_in[7:4] <= 4'd9) && (data_in[3:0] <= 4'd9);
  assign bcd_err   = r_bcd_err;
`else
  assign bcd_err   = 1'b0;
`endif

  // Sweep sequencer: state, hold counter, registered bus outputs and captures.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_idx   <= 4'd0;
      r_cnt   <= c_cnt_one;
      r_addr  <= 8'h00;
      r_drive <= 1'b0;
      r_rd    <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      for (int i = 0; i < 9; i++) begin
        r_data[i] <= 8'h00;
      end
`ifdef BCD_CHECK_EN
      r_bcd_err <= 1'b0;
`endif
    end else begin
      r_done <= 1'b0;
      case (r_state)
        // DONE also samples the request so continuous polling has no gap cycle.
        S_IDLE, S_DONE: begin
          r_cnt <= c_cnt_one;
          if (w_start) begin
            r_state <= S_ADDR;
            r_idx   <= 4'd0;
            r_addr  <= addr_of(4'd0);
            r_drive <= 1'b1;
            r_rd    <= 1'b0;
            r_busy  <= 1'b1;
`ifdef BCD_CHECK_EN
            r_bcd_err <= 1'b0;
`endif
          end else begin
            r_state <= S_IDLE;
            r_drive <= 1'b0;
            r_rd    <= 1'b0;
            r_busy  <= 1'b0;
          end
        end

        S_ADDR: begin
          if (escribe) begin
            r_state <= S_IDLE;
            r_cnt   <= c_cnt_one;
            r_drive <= 1'b0;
            r_rd    <= 1'b0;
            r_busy  <= 1'b0;
          end else if (w_phase_end) begin
            r_state <= S_READ;
            r_cnt   <= c_cnt_one;
            r_rd    <= 1'b1;
          end else begin
            r_cnt <= r_cnt + c_cnt_one;
          end
        end

        S_READ: begin
          if (escribe) begin
            // A writer wins even on the capture clock; the byte is dropped.
            r_state <= S_IDLE;
            r_cnt   <= c_cnt_one;
            r_drive <= 1'b0;
            r_rd    <= 1'b0;
            r_busy  <= 1'b0;
          end else if (w_phase_end) begin
`ifdef BCD_CHECK_EN
            if (w_byte_ok) begin
              r_data[r_idx] <= data_in;
            end else begin
              r_bcd_err <= 1'b1;
            end
`else
            r_data[r_idx] <= data_in;
`endif
            r_cnt <= c_cnt_one;
            r_rd  <= 1'b0;
            if (r_idx < c_last_idx) begin
              r_state <= S_ADDR;
              r_idx   <= r_idx + 4'd1;
              r_addr  <= addr_of(r_idx + 4'd1);
            end else begin
              r_state <= S_DONE;
              r_drive <= 1'b0;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
            end
          end else begin
            r_cnt <= r_cnt + c_cnt_one;
          end
        end

        default: begin
          r_state <= S_IDLE;
          r_cnt   <= c_cnt_one;
          r_drive <= 1'b0;
          r_rd    <= 1'b0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  // Release the shared address bus whenever this block is not sweeping.
  assign address = r_drive ? r_addr : 8'hZZ;
  assign rd      = r_rd;
  assign busy    = r_busy;
  assign done    = r_done;

  assign seg     = r_data[0];
  assign min     = r_data[1];
  assign hora    = r_data[2];
  assign dia     = r_data[3];
  assign mes     = r_data[4];
  assign anio    = r_data[5];
  assign t_seg   = r_data[6];
  assign t_min   = r_data[7];
  assign t_hora  = r_data[8];

endmodule

`default_nettype wire

// File: tb/tb_lectura_rtc.sv
// Self-checking bench for lectura_rtc with HOLD=4. Each sweep's expected
// address/data pairs are queued when the request is issued and popped as the
// sequencer walks the bus.
`timescale 1ns/1ps

module tb_lectura_rtc;

  localparam int HOLD = 4;

  logic       clk;
  logic       reset;
  logic       leer;
  logic       escribe;
  logic [7:0] data_in;
  wire  [7:0] address;
  logic       rd, busy, done, bcd_err;
  logic [7:0] seg, min, hora, dia, mes, anio, t_seg, t_min, t_hora;

  logic [7:0]  obs [9];
  logic [7:0]  m_regs [9];
  logic        m_bcd_err;
  logic [15:0] exp_q [$];

  int vectors;
  int miscompares;

  lectura_rtc #(.HOLD(12'(HOLD))) dut (
    .clk(clk), .reset(reset), .leer(leer), .escribe(escribe),
    .data_in(data_in), .address(address), .rd(rd), .busy(busy), .done(done),
    .seg(seg), .min(min), .hora(hora), .dia(dia), .mes(mes), .anio(anio),
    .t_seg(t_seg), .t_min(t_min), .t_hora(t_hora), .bcd_err(bcd_err)
  );

  always #5 clk = ~clk;

  always_comb begin
    obs[0] = seg;   obs[1] = min;   obs[2] = hora;
    obs[3] = dia;   obs[4] = mes;   obs[5] = anio;
    obs[6] = t_seg; obs[7] = t_min; obs[8] = t_hora;
  end

  function automatic logic [7:0] tb_addr(input int k);
    case (k)
      0: return 8'h21;
      1: return 8'h22;
      2: return 8'h23;
      3: return 8'h24;
      4: return 8'h25;
      5: return 8'h26;
      6: return 8'h41;
      7: return 8'h42;
      default: return 8'h43;
    endcase
  endfunction

  // A two-state simulator resolves an undriven bus to zero.
  function automatic bit released(input logic [7:0] a);
    return (a === 8'hzz) || (a === 8'h00);
  endfunction

  task automatic push_sweep(input logic [7:0] base, input int bad_k);
    for (int k = 0; k < 9; k++) begin
      exp_q.push_back({tb_addr(k), (k == bad_k) ? 8'h5A : (base + 8'(k))});
    end
  endtask

  // Entered on the first ADDR cycle; returns on the DONE cycle or after an abort.
  // abort_kind: 0 none, 1 escribe, 2 reset.
  task automatic watch_sweep(input int abort_kind, input int abort_k, input int abort_c);
    logic [7:0] ea, ed;
    logic       exp_rd;
    m_bcd_err = 1'b0;
    for (int k = 0; k < 9; k++) begin
      if (exp_q.size() == 0) begin
        vectors++; miscompares++;
        $display("FAIL scoreboard: queue empty at idx %0d, required 9 entries", k);
        return;
      end
      {ea, ed} = exp_q.pop_front();
      for (int c = 0; c < 2*HOLD; c++) begin
        exp_rd  = (c >= HOLD);
        data_in = exp_rd ? ed : 8'h00;
        vectors++;
        if ({address, rd, busy, done, bcd_err} !== {ea, exp_rd, 1'b1, 1'b0, m_bcd_err}) begin
          miscompares++;
          $display("FAIL sweep idx%0d cyc%0d: addr/rd/busy/done/err got %h/%b/%b/%b/%b required %h/%b/1/0/%b",
                   k, c, address, rd, busy, done, bcd_err, ea, exp_rd, m_bcd_err);
        end
        if (abort_kind != 0 && k == abort_k && c == abort_c) begin
          if (abort_kind == 1) escribe = 1'b1;
          else reset = 1'b0;
          @(negedge clk);
          escribe = 1'b0;
          reset   = 1'b1;
          data_in = 8'h00;
          if (abort_kind == 2) begin
            for (int i = 0; i < 9; i++) m_regs[i] = 8'h00;
            m_bcd_err = 1'b0;
          end
          vectors++;
          if (!released(address) || {rd, busy, done, bcd_err} !== {3'b000, m_bcd_err}) begin
            miscompares++;
            $display("FAIL abort: addr/rd/busy/done/err got %h/%b/%b/%b/%b required zz/0/0/0/%b",
                     address, rd, busy, done, bcd_err, m_bcd_err);
          end
          exp_q.delete();
          return;
        end
        @(negedge clk);
      end
`ifdef BCD_CHECK_EN
      if (ed[7:4] > 4'd9 || ed[3:0] > 4'd9) m_bcd_err = 1'b1;
      else m_regs[k] = ed;
`else
      m_regs[k] = ed;
`endif
    end
    data_in = 8'h00;
    vectors++;
    if (!released(address) || {rd, busy, done, bcd_err} !== {3'b001, m_bcd_err}) begin
      miscompares++;
      $display("FAIL done cycle: addr/rd/busy/done/err got %h/%b/%b/%b/%b required zz/0/0/1/%b",
               address, rd, busy, done, bcd_err, m_bcd_err);
    end
  endtask

  task automatic test_reset;
    reset = 1'b0;
    repeat (3) @(negedge clk);
    vectors++;
    if (!released(address) || {rd, busy, done, bcd_err} !== 4'b0000) begin
      miscompares++;
      $display("FAIL reset outputs: addr/rd/busy/done/err got %h/%b/%b/%b/%b required zz/0/0/0/0",
               address, rd, busy, done, bcd_err);
    end
    for (int i = 0; i < 9; i++) begin
      m_regs[i] = 8'h00;
      vectors++;
      if (obs[i] !== 8'h00) begin
        miscompares++;
        $display("FAIL reset reg%0d: got %h required 00", i, obs[i]);
      end
    end
    m_bcd_err = 1'b0;
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single_sweep;
    leer = 1'b1;
    push_sweep(8'h10, -1);
    @(negedge clk);
    leer = 1'b0;
    watch_sweep(0, 0, 0);
    for (int i = 0; i < 9; i++) begin
      vectors++;
      if (obs[i] !== 8'h10 + 8'(i)) begin
        miscompares++;
        $display("FAIL single reg%0d: got %h required %h", i, obs[i], 8'h10 + 8'(i));
      end
    end
    @(negedge clk);
    vectors++;
    if (!released(address) || {rd, busy, done} !== 3'b000) begin
      miscompares++;
      $display("FAIL single idle: addr/rd/busy/done got %h/%b/%b/%b required zz/0/0/0",
               address, rd, busy, done);
    end
  endtask

  task automatic test_back_to_back;
    leer = 1'b1;
    push_sweep(8'h30, -1);
    @(negedge clk);
    watch_sweep(0, 0, 0);
    push_sweep(8'h40, -1);
    @(negedge clk);
    leer = 1'b0;
    watch_sweep(0, 0, 0);
    for (int i = 0; i < 9; i++) begin
      vectors++;
      if (obs[i] !== m_regs[i]) begin
        miscompares++;
        $display("FAIL b2b reg%0d: got %h required %h", i, obs[i], m_regs[i]);
      end
    end
    @(negedge clk);
  endtask

  task automatic test_abort;
    leer = 1'b1;
    push_sweep(8'h50, -1);
    @(negedge clk);
    leer = 1'b0;
    watch_sweep(1, 3, HOLD + 1);
    for (int n = 0; n < 6; n++) begin
      vectors++;
      if (!released(address) || {rd, busy, done} !== 3'b000) begin
        miscompares++;
        $display("FAIL abort quiet cyc%0d: addr/rd/busy/done got %h/%b/%b/%b required zz/0/0/0",
                 n, address, rd, busy, done);
      end
      @(negedge clk);
    end
    for (int i = 0; i < 9; i++) begin
      vectors++;
      if (obs[i] !== m_regs[i]) begin
        miscompares++;
        $display("FAIL abort reg%0d: got %h required %h", i, obs[i], m_regs[i]);
      end
    end
  endtask

  task automatic test_reset_mid;
    leer = 1'b1;
    push_sweep(8'h60, -1);
    @(negedge clk);
    leer = 1'b0;
    watch_sweep(2, 5, 2);
    for (int i = 0; i < 9; i++) begin
      vectors++;
      if (obs[i] !== 8'h00) begin
        miscompares++;
        $display("FAIL reset-mid reg%0d: got %h required 00", i, obs[i]);
      end
    end
    for (int n = 0; n < 4; n++) begin
      @(negedge clk);
      vectors++;
      if (!released(address) || {rd, busy, done} !== 3'b000) begin
        miscompares++;
        $display("FAIL reset-mid idle cyc%0d: addr/rd/busy/done got %h/%b/%b/%b required zz/0/0/0",
                 n, address, rd, busy, done);
      end
    end
    leer = 1'b1;
    push_sweep(8'h70, -1);
    @(negedge clk);
    leer = 1'b0;
    watch_sweep(0, 0, 0);
    @(negedge clk);
  endtask

  task automatic test_bcd;
    logic [7:0] prev_min;
    logic [7:0] exp_min;
    logic       exp_err;
    prev_min = m_regs[1];
`ifdef BCD_CHECK_EN
    exp_min = prev_min;
    exp_err = 1'b1;
`else
    exp_min = 8'h5A;
    exp_err = 1'b0;
`endif
    leer = 1'b1;
    push_sweep(8'h20, 1);
    @(negedge clk);
    leer = 1'b0;
    watch_sweep(0, 0, 0);
    @(negedge clk);
    vectors++;
    if ({min, bcd_err} !== {exp_min, exp_err}) begin
      miscompares++;
      $display("FAIL bcd capture: min/err got %h/%b required %h/%b", min, bcd_err, exp_min, exp_err);
    end
    leer = 1'b1;
    push_sweep(8'h10, -1);
    @(negedge clk);
    leer = 1'b0;
    vectors++;
    if (bcd_err !== 1'b0) begin
      miscompares++;
      $display("FAIL bcd clear: err got %b required 0", bcd_err);
    end
    watch_sweep(0, 0, 0);
    @(negedge clk);
  endtask

  initial begin
    clk = 1'b0;
    reset = 1'b0;
    leer = 1'b0;
    escribe = 1'b0;
    data_in = 8'h00;
    m_bcd_err = 1'b0;
    vectors = 0;
    miscompares = 0;
    for (int i = 0; i < 9; i++) m_regs[i] = 8'h00;

    test_reset();
    test_single_sweep();
    test_back_to_back();
    test_abort();
    test_reset_mid();
    test_bcd();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
